// File: rtl/signed_bin2bcd_if.sv
// Handshake and result bundle between the multiplier-side requester and the
// signed binary-to-BCD converter.
interface signed_bin2bcd_if #(
    parameter int W  = 8,
    parameter int ND = 3
) ();
    logic              start;
    logic [W-1:0]      bin;
    logic              busy;
    logic              done;
    logic              sign;
    logic [4*ND-1:0]   bcd;

    modport master (
        output start, bin,
        input  busy, done, sign, bcd
    );

    modport slave (
        input  start, bin,
        output busy, done, sign, bcd
    );
endinterface

// File: rtl/signed_bin2bcd.sv
// Signed binary-to-BCD converter: captures |bin| and its sign, then runs one
// double-dabble correct/shift iteration per clock until all W bits are consumed.
module signed_bin2bcd #(
    parameter int W  = 8,
    parameter int ND = 3
) (
    input  logic             clk,
    input  logic             rst,
    signed_bin2bcd_if.slave  bus
);
    localparam int BW = 4 * ND;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    // Per-digit add-3 correction; digits never carry into each other.
    function automatic logic [BW-1:0] add3_digits(input logic [BW-1:0] s);
        logic [BW-1:0] r;
        r = '0;
        for (int i = 0; i < ND; i++) begin
            if (s[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = s[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = s[4*i +: 4];
            end
        end
        return r;
    endfunction

    state_t          state_r, state_s;
    logic [CW-1:0]   cnt_r, cnt_s;
    logic [W-1:0]    mag_r, mag_s;
    logic [BW-1:0]   scratch_r, scratch_s;
    logic [BW-1:0]   corr_s;
    logic            neg_r, neg_s;
    logic            busy_r, busy_s;
    logic            done_r, done_s;
    logic            sign_r, sign_s;
    logic [BW-1:0]   bcd_r, bcd_s;

    // State and datapath registers; all outputs come straight from here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            mag_r     <= '0;
            scratch_r <= '0;
            neg_r     <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            sign_r    <= 1'b0;
            bcd_r     <= '0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            mag_r     <= mag_s;
            scratch_r <= scratch_s;
            neg_r     <= neg_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            sign_r    <= sign_s;
            bcd_r     <= bcd_s;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        mag_s     = mag_r;
        scratch_s = scratch_r;
        neg_s     = neg_r;
        busy_s    = busy_r;
        done_s    = 1'b0;
        sign_s    = sign_r;
        bcd_s     = bcd_r;
        corr_s    = add3_digits(scratch_r);

        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    neg_s = bus.bin[W-1];
                    // W-bit unsigned negate: the most negative input maps to 2^(W-1).
                    if (bus.bin[W-1]) begin
                        mag_s = ~bus.bin + {{(W-1){1'b0}}, 1'b1};
                    end else begin
                        mag_s = bus.bin;
                    end
                    scratch_s = '0;
                    cnt_s     = '0;
                    busy_s    = 1'b1;
                    state_s   = CONV;
                end else begin
                    state_s = IDLE;
                end
            end
            CONV: begin
                scratch_s = {corr_s[BW-2:0], mag_r[W-1]};
                mag_s     = {mag_r[W-2:0], 1'b0};
                cnt_s     = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                if (cnt_r == CW'(W - 1)) begin
                    bcd_s   = {corr_s[BW-2:0], mag_r[W-1]};
                    sign_s  = neg_r;
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                    state_s = IDLE;
                end else begin
                    state_s = CONV;
                end
            end
            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.sign = sign_r;
    assign bus.bcd  = bcd_r;
endmodule

// File: doc/signed_bin2bcd.md
Name: signed_bin2bcd

Overview:
- Sequential signed binary-to-BCD converter. Sits directly downstream of the calculator's shift-add signed multiplier.
- Consumes the multiplier's 8-bit two's-complement product when the multiplier's done is seen. Produces a sign flag plus packed BCD digits for the calculator display.
- Uses the double-dabble algorithm: one shift/correct iteration per clock, with a start/done handshake.

Parameters:
- W, 8, input width in bits; two's-complement.
- ND, 3, number of BCD output digits. Must satisfy 10^ND > 2^(W-1) so that magnitude 2^(W-1) fits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  conversion request; sampled on rising clk while idle.
- bin  input  W  signed operand; captured on the edge that accepts start.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when sign and bcd are updated.
- sign  output  1  1 when the captured operand was negative.
- bcd  output  4*ND  magnitude in packed BCD; digit 0 (units) in bits [3:0].

Behaviour:
- Reset (rst=0, asynchronous, no clock needed):
  - state=IDLE.
  - busy=0, done=0, sign=0, bcd=0.
  - Internal shift register and counter cleared.
- States: IDLE, CONV.
- IDLE:
  - On a rising edge with start=1: capture sign_r=bin[W-1] and mag=|bin|, computed in W-bit unsigned (bin=-2^(W-1) gives 2^(W-1)).
  - Clear the BCD scratch register and set cnt=0, busy=1, state=CONV.
  - start=0: stay in IDLE; outputs hold.
- CONV, one iteration per edge:
  - Every scratch digit >=5 gets +3.
  - Then shift {scratch, mag} left by 1.
  - cnt increments.
- On the edge completing iteration W:
  - bcd <= final scratch; sign <= sign_r.
  - done=1 for exactly one cycle; busy=0; state=IDLE.
- Latency: done is high in the cycle after the W-th edge following the accepting edge. For W=8 that is 8 clocks after start is sampled.
- Output hold: sign and bcd change only on the done edge or on reset. They hold the last result indefinitely.
- done is registered and deasserts on the next edge unconditionally.
- start while busy=1 is ignored. bin changes during CONV have no effect.
- start=1 in the cycle done=1 (state is IDLE) is accepted. That back-to-back conversion's done follows exactly W clocks later.
- Zero operand gives sign=0, bcd=0.
- sign=1 implies a nonzero magnitude; the converter never produces a negative zero.
- Reset mid-conversion: the conversion is aborted with no done pulse, and all outputs go to their reset values immediately.
- Arithmetic:
  - Digit correction is 4-bit add-3 with no carry between digits.
  - The scratch register is 4*ND bits; no overflow occurs given the ND constraint.

Test Plan:
1. Reset: drive rst=0 with clk stopped -> busy=0, done=0, sign=0, bcd=12'h000 immediately. Release rst, idle 3 clocks -> no done.
2. bin=8'hF2 (-14), start pulsed 1 clk -> done pulses once, 8 clks after the start edge; sign=1, bcd=12'h014. Values hold for 10 further clocks.
3. Extremes:
   - bin=8'h80 -> sign=1, bcd=12'h128.
   - bin=8'h7F -> sign=0, bcd=12'h127.
   - bin=8'hFF -> sign=1, bcd=12'h001.
   - bin=8'h00 -> sign=0, bcd=12'h000.
4. Busy rejection: start with bin=8'h19 (25); on clock 3 assert start with bin=8'hE7 -> single done, sign=0, bcd=12'h025. No second done within 20 clocks.
5. Back-to-back: start bin=8'h63 (99). Hold start=1 with bin=8'hA0 (-96) during the done cycle -> first done gives bcd=12'h099, sign=0. Second done exactly 8 clks later gives sign=1, bcd=12'h096.
6. Mid-conversion reset: start bin=8'h55, pull rst=0 asynchronously after clock 4 -> outputs zero at once, no done. After release, start bin=8'h0C -> done, bcd=12'h012, sign=0.
